// File: rtl/riscv_alu_exec.sv
// riscv_alu_exec: execute-stage ALU with valid/ready handshakes on input and output.
// Define RISCV_ALU_MUL_EN to enable the iterative shift-add multiplier on code 1000.
module riscv_alu_exec #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_NOR = 4'b1100,
        OP_MUL = 4'b1000
    } alu_op_e;

    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic            accept;
    logic            busy;
    logic            is_mul;
    logic            mul_done;
    logic [XLEN-1:0] mul_res;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_NOR:  alu_res = ~(src_a | src_b);
            default: alu_ill = 1'b1;
        endcase
    end

    assign in_ready = !busy && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

`ifdef RISCV_ALU_MUL_EN
    typedef enum logic {
        IDLE,
        MUL
    } state_e;

    localparam int unsigned CW = $clog2(XLEN);

    state_e          state;
    state_e          state_nxt;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mul_a;
    logic [XLEN-1:0] mul_b;
    logic [XLEN-1:0] acc_step;

    assign is_mul   = (alu_ctrl == OP_MUL);
    assign busy     = (state == MUL);
    assign mul_done = (state == MUL) && (cnt == CW'(XLEN-1));
    assign acc_step = acc + (mul_b[0] ? mul_a : '0);
    assign mul_res  = acc_step;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mul) state_nxt = MUL;
            MUL:     if (mul_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // One multiplier bit per cycle, LSB first: A shifts up as B shifts down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            mul_a <= '0;
            mul_b <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (state == MUL) begin
            acc   <= acc_step;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            cnt   <= cnt + CW'(1);
        end else if (accept && is_mul) begin
            acc   <= '0;
            mul_a <= src_a;
            mul_b <= src_b;
            cnt   <= '0;
        end
    end
`else
    assign is_mul   = 1'b0;
    assign busy     = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (mul_done) begin
            result    <= mul_res;
            zero      <= (mul_res == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
        end else if (accept && is_mul) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            result    <= alu_res;
            zero      <= (alu_res == '0);
            illegal   <= alu_ill;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_alu_exec.sv
// Self-checking bench for riscv_alu_exec: directed corner cases followed by
// random traffic, all compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_riscv_alu_exec;

    localparam int unsigned XLEN = 32;

`ifdef RISCV_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    riscv_alu_exec #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    // Reference model: output register contents plus remaining multiply cycles
    bit              m_ov;
    logic [XLEN-1:0] m_res;
    bit              m_zero;
    bit              m_ill;
    int              m_left;
    logic [XLEN-1:0] m_a;
    logic [XLEN-1:0] m_b;

    task automatic check_val(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN:0] ref_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            4'b0000: return {1'b0, a & b};
            4'b0001: return {1'b0, a | b};
            4'b0010: return {1'b0, a + b};
            4'b0110: return {1'b0, a - b};
            4'b0111: return {1'b0, (sa < sb) ? XLEN'(1) : XLEN'(0)};
            4'b1100: return {1'b0, ~(a | b)};
            default: return {1'b1, {XLEN{1'b0}}};
        endcase
    endfunction

    task automatic model_reset();
        m_ov   = 1'b0;
        m_res  = '0;
        m_zero = 1'b1;
        m_ill  = 1'b0;
        m_left = 0;
        m_a    = '0;
        m_b    = '0;
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input bit ordy, input bit fl);
        in_valid  = v;
        alu_ctrl  = op;
        src_a     = a;
        src_b     = b;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Check outputs at negedge, advance the model for the coming edge, return at posedge+1.
    task automatic cycle();
        bit              exp_rdy;
        bit              acc;
        bit              hs;
        logic [XLEN:0]   r;
        @(negedge clk);
        exp_rdy = (m_left == 0) && (!m_ov || out_ready) && !flush;
        check_val("in_ready",  in_ready,  exp_rdy);
        check_val("out_valid", out_valid, m_ov);
        check_val("result",    result,    m_res);
        check_val("zero",      zero,      m_zero);
        check_val("illegal",   illegal,   m_ill);
        acc = in_valid && exp_rdy;
        hs  = m_ov && out_ready;
        if (flush) begin
            m_ov   = 1'b0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_res  = m_a * m_b;
                m_zero = (m_res == 0);
                m_ill  = 1'b0;
                m_ov   = 1'b1;
            end
        end else if (acc) begin
            if (MUL_EN && alu_ctrl == 4'b1000) begin
                m_a    = src_a;
                m_b    = src_b;
                m_left = XLEN;
                m_ov   = 1'b0;
            end else begin
                r      = ref_op(alu_ctrl, src_a, src_b);
                m_res  = r[XLEN-1:0];
                m_ill  = r[XLEN];
                m_zero = (m_res == 0);
                m_ov   = 1'b1;
            end
        end else if (hs) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(XLEN-1){1'b0}}};
            3:       return XLEN'(1);
            default: return XLEN'($urandom);
        endcase
    endfunction

    logic [3:0] op_tab [10] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h8, 4'h5, 4'hF, 4'h3};

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();

        // Back-to-back single-cycle ops with the consumer always ready
        drive(1'b1, 4'h2, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
        cycle();
        check_val("add_res", result, 32'h0);
        check_val("add_zero", zero, 1'b1);
        drive(1'b1, 4'h6, 32'd5, 32'd7, 1'b1, 1'b0);
        cycle();
        check_val("sub_res", result, 32'hFFFF_FFFE);
        check_val("sub_valid", out_valid, 1'b1);
        drive(1'b1, 4'h7, 32'h8000_0000, 32'h1, 1'b1, 1'b0);
        cycle();
        check_val("slt_res", result, 32'h1);
        drive(1'b1, 4'hC, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle();
        check_val("nor_res", result, 32'hFFFF_FFFF);
        drive(1'b0, 4'h0, '0, '0, 1'b1, 1'b0);
        cycle();

        // Backpressure, then same-cycle handoff and accept
        drive(1'b1, 4'h0, 32'hF0F0, 32'hFF00, 1'b1, 1'b0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h1, 32'h0F, 32'hF0, 1'b0, 1'b0);
            cycle();
            check_val("bp_hold", result, 32'hF000);
        end
        drive(1'b1, 4'h1, 32'h0F, 32'hF0, 1'b1, 1'b0);
        cycle();
        check_val("bp_or", result, 32'hFF);

        // Unsupported code, then recovery
        drive(1'b1, 4'h5, 32'd3, 32'd4, 1'b1, 1'b0);
        cycle();
        check_val("ill_flag", illegal, 1'b1);
        check_val("ill_res", result, 32'h0);
        drive(1'b1, 4'h2, 32'd1, 32'd1, 1'b1, 1'b0);
        cycle();
        check_val("ill_clear", illegal, 1'b0);

        // Multiply (or illegal when the multiplier is not built)
        drive(1'b1, 4'h8, 32'hFFFF, 32'h1_0001, 1'b1, 1'b0);
        cycle();
`ifdef RISCV_ALU_MUL_EN
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 4'h2, rand_opnd(), rand_opnd(), 1'b1, 1'b0);
            cycle();
        end
        check_val("mul_res", result, 32'hFFFF_FFFF);
        check_val("mul_valid", out_valid, 1'b1);
`else
        check_val("mul_ill", illegal, 1'b1);
        check_val("mul_res0", result, 32'h0);
`endif
        drive(1'b0, 4'h0, '0, '0, 1'b1, 1'b0);
        cycle();

        // Flush partway through a multiply
        drive(1'b1, 4'h8, 32'h1234, 32'h5678, 1'b1, 1'b0);
        cycle();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 4'h0, '0, '0, 1'b1, 1'b0);
            cycle();
        end
        drive(1'b1, 4'h2, 32'd9, 32'd9, 1'b1, 1'b1);
        cycle();
        drive(1'b0, 4'h0, '0, '0, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 4'h2, 32'd2, 32'd2, 1'b1, 1'b0);
        cycle();
        check_val("flush_add", result, 32'd4);

        // Asynchronous reset with a held result
        drive(1'b1, 4'h0, 32'hFF, 32'h0F, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_valid", out_valid, 1'b0);
        check_val("rst_res", result, 32'h0);
        check_val("rst_zero", zero, 1'b1);
        check_val("rst_ill", illegal, 1'b0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Asynchronous reset during a multiply must not leak a result
        drive(1'b1, 4'h8, 32'd7, 32'd6, 1'b1, 1'b0);
        cycle();
        repeat (5) begin
            drive(1'b0, 4'h0, '0, '0, 1'b1, 1'b0);
            cycle();
        end
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 4'h0, '0, '0, 1'b1, 1'b0);
            cycle();
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, op_tab[$urandom_range(0, 9)], rand_opnd(), rand_opnd(),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_alu_exec.md
Name: riscv_alu_exec

Overview:
- Execute-stage ALU that consumes the 4-bit alu_ctrl code produced by the ALU control decoder, together with two operands.
- Registers one result per accepted operation behind valid/ready handshakes on both sides.
- Sits between the ID/EX operand latch and the EX/MEM register.
- Single-cycle logic ops complete at 1 op/cycle; the optional iterative multiplier stalls the input side while running.

Parameters:
XLEN, 32, operand/result width in bits (>= 4)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of in-flight/held op
in_valid  input  1  operation offered
in_ready  output  1  operation accepted when in_valid & in_ready
alu_ctrl  input  4  operation code
src_a  input  XLEN  operand A
src_b  input  XLEN  operand B
out_valid  output  1  result held for consumer
out_ready  input  1  consumer takes result when out_valid & out_ready
result  output  XLEN  operation result
zero  output  1  result == 0
illegal  output  1  alu_ctrl was unsupported

Behaviour:
- Reset (rst_n low, async): state IDLE, out_valid=0, result=0, zero=1, illegal=0, multiplier counter/accumulator=0. in_ready=1 once reset deasserts (combinational from state).
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (mod 2^XLEN, carry discarded)
  - 0110 SUB (A-B mod 2^XLEN)
  - 0111 SLT (signed two's-complement A<B, result 1 or 0, zero-extended)
  - 1100 NOR
  - 1000 MUL (only with the optional feature)
- Any other code: result=0, zero=1, illegal=1, 1-cycle latency.
- zero and illegal are registered with result and change only when result is loaded.
- States: IDLE, MUL.
- in_ready = (state==IDLE) & (~out_valid | out_ready). Combinational, no dependence on in_valid.
- IDLE, accept of a non-MUL op: result/zero/illegal loaded at that edge; out_valid=1 from the next cycle (latency 1).
  - Accept and output handoff in the same cycle is legal, giving back-to-back throughput of 1/cycle.
- Output hold: while out_valid & ~out_ready, result/zero/illegal are stable and in_ready=0.
- out_valid clears on handoff when no new op is accepted in the same cycle.
- IDLE, accept of MUL: latch A and B, clear accumulator, counter=0, go to MUL, and clear out_valid (the prior result was taken by the same-cycle handoff rule).
- MUL: shift-add, one bit of B per cycle, LSB first.
  - After XLEN cycles in MUL: result = low XLEN bits of A*B, zero updated, illegal=0, out_valid=1, return to IDLE.
  - Accept edge k; out_valid visible after edge k+XLEN.
  - in_ready=0 throughout MUL.
- flush (sync, highest priority after reset): at the edge, out_valid=0, state→IDLE, counter=0. Any input offered that cycle is not accepted (in_ready forced 0 while flush=1). result retains its old value.
- Reset mid-MUL: aborts immediately; no partial result is ever presented.
- Operands are sampled only at the accept edge; changes to src_a/src_b/alu_ctrl afterwards have no effect.

Optional Feature:
- Macro: RISCV_ALU_MUL_EN.
- Defined: code 1000 runs the iterative multiplier and MUL state as above.
- Undefined: MUL state, counter and accumulator are absent. Code 1000 is treated as illegal (result 0, zero 1, illegal 1, latency 1), and in_ready depends only on output occupancy.

Test Plan:
- Reset mid-op: assert rst_n=0 with out_valid=1 → out_valid=0, result=0, zero=1, illegal=0 immediately, without waiting for a clock edge.
- ADD/SUB/SLT/NOR with out_ready=1 held, back-to-back:
  - ADD 0xFFFFFFFF+1 → result 0, zero=1.
  - SUB 5-7 → 0xFFFFFFFE.
  - SLT 0x80000000 vs 1 → 1.
  - NOR 0,0 → 0xFFFFFFFF.
  - One result per cycle, each 1 cycle after its accept.
- Backpressure: AND 0xF0F0,0xFF00 accepted, out_ready=0 for 3 cycles → result 0xF000 held stable and in_ready=0 for those cycles. out_ready=1 with a new OR offered → handoff and accept in the same cycle.
- Illegal code 0101 with A=3,B=4 → result 0, zero=1, illegal=1 after 1 cycle. Next legal op → illegal=0.
- MUL (macro defined): 0xFFFF x 0x10001 → 0xFFFFFFFF, out_valid after exactly 32 cycles, in_ready=0 throughout. Without the macro, the same stimulus → illegal=1 after 1 cycle.
- Flush: assert flush on cycle 10 of a MUL → out_valid never asserts for that op, state IDLE, in_ready=1 next cycle. A following ADD 2+2 → 4.
